// File: rtl/onewire_sensor_emu.sv
// AM2302-style single-wire sensor emulator. Waits for a long enough host low
// pulse, then answers with the ack preamble and an MSB-first frame, with an
// optional 8-bit additive checksum appended as the last byte.
module onewire_sensor_emu #(
  parameter int CLKS_PER_US    = 10,
  parameter int DATA_BITS      = 32,
  parameter int CHKSUM_EN      = 1,
  parameter int T_START_MIN_US = 800,
  parameter int T_WAIT_US      = 30,
  parameter int T_ACK_US       = 80,
  parameter int T_BITL_US      = 50,
  parameter int T_ZERO_US      = 26,
  parameter int T_ONE_US       = 70,
  parameter int T_HOLD_US      = 1000
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 enable,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic                 sda_do,
  input  logic [DATA_BITS-1:0] sensor_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 start_err
);

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int FRAME_BITS = DATA_BITS + ((CHKSUM_EN != 0) ? 8 : 0);

  localparam int C_START = T_START_MIN_US * CLKS_PER_US;
  localparam int C_WAIT  = T_WAIT_US * CLKS_PER_US;
  localparam int C_ACK   = T_ACK_US * CLKS_PER_US;
  localparam int C_BITL  = T_BITL_US * CLKS_PER_US;
  localparam int C_ZERO  = T_ZERO_US * CLKS_PER_US;
  localparam int C_ONE   = T_ONE_US * CLKS_PER_US;
  localparam int C_HOLD  = T_HOLD_US * CLKS_PER_US;

  // The counter must hold the longest interval of any state; hold and start
  // dominate with sane settings, the rest are folded in for safety.
  localparam int C_MAX = maxOf(maxOf(maxOf(C_HOLD, C_START), maxOf(C_WAIT, C_ACK)),
                               maxOf(maxOf(C_BITL, C_ZERO), C_ONE));
  localparam int CNT_W = $clog2(C_MAX + 1);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  // Terminal counts: a state lasting N cycles leaves when the counter reads N-1.
  localparam logic [CNT_W-1:0] K_START = CNT_W'(C_START);
  localparam logic [CNT_W-1:0] L_WAIT  = CNT_W'(C_WAIT - 1);
  localparam logic [CNT_W-1:0] L_ACK   = CNT_W'(C_ACK - 1);
  localparam logic [CNT_W-1:0] L_BITL  = CNT_W'(C_BITL - 1);
  localparam logic [CNT_W-1:0] L_ZERO  = CNT_W'(C_ZERO - 1);
  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(C_ONE - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(C_HOLD - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HOST_LOW,
    S_WAIT,
    S_ACK_L,
    S_ACK_H,
    S_BIT_L,
    S_BIT_H,
    S_END_L,
    S_HOLD
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_sync1;
  logic                    r_sync2;
  logic                    r_sdaPrev;
  logic [CNT_W-1:0]        r_cnt;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [BIT_W-1:0]        r_bits;
  logic [FRAME_BITS-1:0]   w_frame;
  logic                    w_sSda;
  logic                    w_sdaRise;
  logic                    w_load;
  logic                    w_shift;

  generate
    if (CHKSUM_EN != 0) begin : g_chk
      logic [7:0] w_sum;
      // Checksum is the byte-wise sum of the payload, truncated to 8 bits.
      always_comb begin
        w_sum = '0;
        for (int i = 0; i < DATA_BITS / 8; i++) begin
          w_sum = w_sum + sensor_data[i*8 +: 8];
        end
      end
      assign w_frame = {sensor_data, w_sum};
    end else begin : g_noChk
      assign w_frame = sensor_data;
    end
  endgenerate

  assign w_sSda    = r_sync2;
  assign w_sdaRise = r_sync2 & ~r_sdaPrev;

  // Two-stage synchroniser plus one delayed copy for edge detection; idles high like the bus.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_sdaPrev <= 1'b1;
    end else begin
      r_sync1   <= sda_in;
      r_sync2   <= r_sync1;
      r_sdaPrev <= r_sync2;
    end
  end

  // State register; reset drops straight to IDLE so the bus is released at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Single interval counter, restarted on every state change and saturating at full scale.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if ((w_next != r_state) || (r_state == S_IDLE)) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Frame shift register and remaining-bit count, loaded when the start pulse is accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shift <= '0;
      r_bits  <= '0;
    end else if (w_load) begin
      r_shift <= w_frame;
      r_bits  <= BIT_W'(FRAME_BITS);
    end else if (w_shift) begin
      r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
      r_bits  <= r_bits - BIT_W'(1);
    end
  end

  // Next-state and bus/status decode; the bus is only driven from ACK_L through END_L.
  always_comb begin
    w_next     = r_state;
    sda_oe     = 1'b0;
    sda_do     = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    start_err  = 1'b0;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && !w_sSda) w_next = S_HOST_LOW;
      end
      S_HOST_LOW: begin
        if (w_sdaRise) begin
          if (r_cnt >= K_START) begin
            w_load = 1'b1;
            w_next = S_WAIT;
          end else begin
            start_err = 1'b1;
            w_next    = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (r_cnt == L_WAIT) w_next = S_ACK_L;
      end
      S_ACK_L: begin
        busy   = 1'b1;
        sda_oe = 1'b1;
        if (r_cnt == L_ACK) w_next = S_ACK_H;
      end
      S_ACK_H: begin
        busy   = 1'b1;
        sda_oe = 1'b1;
        sda_do = 1'b1;
        if (r_cnt == L_ACK) w_next = S_BIT_L;
      end
      S_BIT_L: begin
        busy   = 1'b1;
        sda_oe = 1'b1;
        if (r_cnt == L_BITL) w_next = S_BIT_H;
      end
      S_BIT_H: begin
        busy   = 1'b1;
        sda_oe = 1'b1;
        sda_do = 1'b1;
        if (r_cnt == (r_shift[FRAME_BITS-1] ? L_ONE : L_ZERO)) begin
          w_shift = 1'b1;
          w_next  = (r_bits == BIT_W'(1)) ? S_END_L : S_BIT_L;
        end
      end
      S_END_L: begin
        busy   = 1'b1;
        sda_oe = 1'b1;
        if (r_cnt == L_BITL) begin
          frame_done = 1'b1;
          w_next     = S_HOLD;
        end
      end
      S_HOLD: begin
        busy = 1'b1;
        if (r_cnt == L_HOLD) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_onewire_sensor_emu.sv
// Directed bench for onewire_sensor_emu: a host model pulls the line low,
// the bench decodes the emulator's reply and checks widths and frame contents.
module tb_onewire_sensor_emu;

  localparam int CPU1  = 1;
  localparam int CPU2  = 2;
  localparam int LIMIT = 20000;

  logic        CLK      = 1'b0;
  logic        RST_N    = 1'b1;
  logic        enable   = 1'b1;
  logic        hostLow1 = 1'b0;
  logic        hostLow2 = 1'b0;
  logic [31:0] data1    = 32'h12345678;
  logic [15:0] data2    = 16'hA5F0;
  int          sel      = 0;

  logic oe1, do1, busy1, done1, err1, line1;
  logic oe2, do2, busy2, done2, err2, line2;
  logic curOe, curDo, curBusy, curDone, curErr;

  int vectors     = 0;
  int miscompares = 0;
  int oeSamples   = 0;
  int busySamples = 0;
  int errSamples  = 0;
  int doneSamples = 0;
  logic hung;

  // Open-drain bus with pull-up: emulator drive wins, otherwise the host decides.
  assign line1 = oe1 ? do1 : ~hostLow1;
  assign line2 = oe2 ? do2 : ~hostLow2;

  assign curOe   = (sel == 0) ? oe1   : oe2;
  assign curDo   = (sel == 0) ? do1   : do2;
  assign curBusy = (sel == 0) ? busy1 : busy2;
  assign curDone = (sel == 0) ? done1 : done2;
  assign curErr  = (sel == 0) ? err1  : err2;

  onewire_sensor_emu #(.CLKS_PER_US(CPU1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .sda_in(line1),
    .sda_oe(oe1), .sda_do(do1), .sensor_data(data1),
    .busy(busy1), .frame_done(done1), .start_err(err1)
  );

  onewire_sensor_emu #(.CLKS_PER_US(CPU2), .DATA_BITS(16), .CHKSUM_EN(0)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .sda_in(line2),
    .sda_oe(oe2), .sda_do(do2), .sensor_data(data2),
    .busy(busy2), .frame_done(done2), .start_err(err2)
  );

  always #5 CLK = ~CLK;

  // Running sample counts of the selected emulator's status, read as deltas.
  always @(negedge CLK) begin
    if (curOe)   oeSamples++;
    if (curBusy) busySamples++;
    if (curErr)  errSamples++;
    if (curDone) doneSamples++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int which, input int cycles);
    if (which == 0) hostLow1 = 1'b1; else hostLow2 = 1'b1;
    repeat (cycles) @(negedge CLK);
    if (which == 0) hostLow1 = 1'b0; else hostLow2 = 1'b0;
  endtask

  task automatic measureWhile(input logic wantOe, input logic wantDo, output int width);
    width = 0;
    while (!hung && curOe === wantOe && curDo === wantDo) begin
      width++;
      if (width >= LIMIT) begin
        hung = 1'b1;
        checkOutput("timeout", 1, 0);
      end
      @(negedge CLK);
    end
  endtask

  task automatic receiveFrame(input int cpu, input int nBits, input logic [63:0] expFrame,
                              input bit holdPulse, input bit midChange, input string tag);
    int n, w, lowBad, highBad, doneBefore, errBefore, oeHold;
    bit firstOne;
    logic expBit;
    logic [63:0] got;
    hung       = 1'b0;
    doneBefore = doneSamples;
    errBefore  = errSamples;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      if (midChange && n == 10) begin
        enable = 1'b0;
        data1  = 32'h0;
      end
    end while (!curOe && n < LIMIT);
    // Release is seen on the first edge, two synchroniser stages, then the wait interval.
    checkOutput({tag, ".releaseToAck"}, n, 30 * cpu + 3);
    checkOutput({tag, ".busyInAck"}, curBusy, 1);
    measureWhile(1'b1, 1'b0, w);
    checkOutput({tag, ".ackLow"}, w, 80 * cpu);
    measureWhile(1'b1, 1'b1, w);
    checkOutput({tag, ".ackHigh"}, w, 80 * cpu);
    got = '0; lowBad = 0; highBad = 0; firstOne = 1'b0;
    for (int i = 0; i < nBits; i++) begin
      expBit = expFrame[nBits-1-i];
      measureWhile(1'b1, 1'b0, w);
      if (w != 50 * cpu) lowBad++;
      measureWhile(1'b1, 1'b1, w);
      got = {got[62:0], (w > 48 * cpu)};
      if (w != (expBit ? 70 : 26) * cpu) highBad++;
      if (i == 0) checkOutput({tag, ".firstBitHigh"}, w, (expBit ? 70 : 26) * cpu);
      if (expBit && !firstOne) begin
        firstOne = 1'b1;
        checkOutput({tag, ".firstOneHigh"}, w, 70 * cpu);
      end
    end
    checkOutput({tag, ".frame"}, got, expFrame);
    checkOutput({tag, ".badLowWidths"}, lowBad, 0);
    checkOutput({tag, ".badHighWidths"}, highBad, 0);
    measureWhile(1'b1, 1'b0, w);
    checkOutput({tag, ".endLow"}, w, 50 * cpu);
    checkOutput({tag, ".frameDonePulses"}, doneSamples - doneBefore, 1);
    n = 0; oeHold = 0;
    while (curBusy && n < LIMIT) begin
      if (curOe) oeHold++;
      if (holdPulse && n == 100) hostLow1 = 1'b1;
      if (holdPulse && n == 600) hostLow1 = 1'b0;
      @(negedge CLK);
      n++;
    end
    if (holdPulse) hostLow1 = 1'b0;
    checkOutput({tag, ".holdLen"}, n, 1000 * cpu);
    checkOutput({tag, ".holdDrive"}, oeHold, 0);
    checkOutput({tag, ".startErrs"}, errSamples - errBefore, 0);
  endtask

  // Last-resort guard so the run always terminates.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int errB, oeB, busyB, n, rises;
    logic prevHigh;

    // Reset state
    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset.oe", oe1, 0);
    checkOutput("reset.do", do1, 0);
    checkOutput("reset.busy", busy1, 0);
    checkOutput("reset.done", done1, 0);
    checkOutput("reset.err", err1, 0);
    checkOutput("reset.oe2", oe2, 0);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);

    // Frame A: 32'h12345678 plus checksum 8'h14
    $display("[TB] frame A");
    applyStimulus(0, 1000 * CPU1);
    receiveFrame(CPU1, 40, 64'h12_3456_7814, 1'b0, 1'b0, "frameA");

    // Too-short host pulse is rejected with a single error pulse
    $display("[TB] short start pulse");
    errB = errSamples; oeB = oeSamples; busyB = busySamples;
    applyStimulus(0, 500 * CPU1);
    repeat (50) @(negedge CLK);
    checkOutput("short.errPulses", errSamples - errB, 1);
    checkOutput("short.oeSamples", oeSamples - oeB, 0);
    checkOutput("short.busySamples", busySamples - busyB, 0);

    // Reset while bit 20 is high
    $display("[TB] reset mid-frame");
    applyStimulus(0, 1000 * CPU1);
    rises = 0; n = 0; prevHigh = 1'b0;
    while (rises < 22 && n < LIMIT) begin
      @(negedge CLK);
      n++;
      if (curOe && curDo && !prevHigh) rises++;
      prevHigh = curOe & curDo;
    end
    checkOutput("abort.reachBit20", rises, 22);
    checkOutput("abort.wasDriving", oe1, 1);
    #2 RST_N = 1'b0;
    #1;
    checkOutput("abort.oe", oe1, 0);
    checkOutput("abort.busy", busy1, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);

    // Frame B: saturating host low, data changes and enable drops after the latch,
    // and a short host pulse lands inside the holdoff
    $display("[TB] frame B");
    data1 = 32'hDEADBEEF;
    applyStimulus(0, 1100 * CPU1);
    receiveFrame(CPU1, 40, 64'hDE_ADBE_EF38, 1'b1, 1'b1, "frameB");

    // With enable low a valid start gets no response
    $display("[TB] enable low");
    errB = errSamples; oeB = oeSamples; busyB = busySamples;
    applyStimulus(0, 1000 * CPU1);
    repeat (100) @(negedge CLK);
    checkOutput("disabled.oeSamples", oeSamples - oeB, 0);
    checkOutput("disabled.busySamples", busySamples - busyB, 0);
    checkOutput("disabled.errPulses", errSamples - errB, 0);

    // Frame C: normal service once enabled again
    $display("[TB] frame C");
    enable = 1'b1;
    data1  = 32'hCAFEF00D;
    repeat (10) @(negedge CLK);
    applyStimulus(0, 1000 * CPU1);
    receiveFrame(CPU1, 40, 64'hCA_FEF0_0DC5, 1'b0, 1'b0, "frameC");

    // Frame D: 16-bit payload, no checksum, two clocks per microsecond
    $display("[TB] frame D");
    sel = 1;
    repeat (5) @(negedge CLK);
    applyStimulus(1, 1000 * CPU2);
    receiveFrame(CPU2, 16, 64'hA5F0, 1'b0, 1'b0, "frameD");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/onewire_sensor_emu.md
Name: onewire_sensor_emu

Overview:
- Synthesizable, parametrised single-wire sensor emulator for the AM2302 protocol. It is the clocked successor to the behavioural sensor model.
- It sits on the master's SDA net, either in FPGA test harnesses or as a sensor stand-in during DW8051 system simulation.
- It validates the host start pulse, then drives the ack preamble and an N-bit frame. It can optionally append an auto-computed checksum byte.
- All timing is in clock cycles derived from one scale parameter.

Parameters:
- CLKS_PER_US, 10, clock cycles per microsecond; every timing below is in us × CLKS_PER_US.
- DATA_BITS, 32, payload width; must be a multiple of 8 when CHKSUM_EN=1.
- CHKSUM_EN, 1, 1 = append 8-bit checksum after payload.
- T_START_MIN_US, 800, minimum host low pulse accepted as start.
- T_WAIT_US, 30, delay from host release to ack low.
- T_ACK_US, 80, ack low time and ack high time (each).
- T_BITL_US, 50, low time preceding each bit and the end pulse.
- T_ZERO_US, 26, high time for a 0 bit.
- T_ONE_US, 70, high time for a 1 bit.
- T_HOLD_US, 1000, post-frame holdoff during which the bus is ignored.

Ports:
- CLK, input, 1, system clock.
- RST_N, input, 1, asynchronous active-low reset.
- enable, input, 1, permits a new transaction; sampled in IDLE only.
- sda_in, input, 1, SDA line level, asynchronous.
- sda_oe, output, 1, 1 = drive SDA with sda_do, 0 = release.
- sda_do, output, 1, drive value.
- sensor_data, input, DATA_BITS, payload; latched at host release.
- busy, output, 1, high from accepted start until end of holdoff.
- frame_done, output, 1, one-cycle pulse at end of END_L.
- start_err, output, 1, one-cycle pulse on a rejected (too short) host pulse.

Behaviour:
- Reset (async, RST_N=0):
  - State returns to IDLE; counters and shift register are cleared.
  - Outputs: sda_oe=0, sda_do=0, busy=0, frame_done=0, start_err=0.
  - The synchroniser flops are set to 1.
  - Reset mid-frame releases the bus immediately, asynchronously.
- Input path:
  - sda_in passes through a 2-FF synchroniser to give s_sda, so there is 2 cycles of latency.
  - Edge detection uses s_sda versus its previous value.
- Cycle counter:
  - One cycle counter, cleared on every state entry.
  - Sized for the largest of T_HOLD and T_START_MIN. It saturates and never wraps.
- FSM:
  - IDLE → HOST_LOW on s_sda=0 while enable=1.
  - HOST_LOW: count while s_sda=0. On s_sda rising:
    - count ≥ T_START_MIN → WAIT. In the same cycle, latch sensor_data into the shift register and compute the checksum.
    - count < T_START_MIN → pulse start_err, go to IDLE, no drive.
  - WAIT: released for T_WAIT cycles → ACK_L.
  - ACK_L: oe=1, do=0 for T_ACK → ACK_H.
  - ACK_H: oe=1, do=1 for T_ACK → BIT_L.
  - BIT_L: oe=1, do=0 for T_BITL → BIT_H.
  - BIT_H: oe=1, do=1 for T_ONE or T_ZERO, selected by the current MSB. Then shift left and decrement the bit count. If the count is nonzero → BIT_L, else → END_L.
  - END_L: oe=1, do=0 for T_BITL, then pulse frame_done → HOLD.
  - HOLD: oe=0. Ignore the bus for T_HOLD → IDLE.
- Frame contents:
  - Total bits = DATA_BITS + 8·CHKSUM_EN, sent MSB first.
  - Checksum = sum of the DATA_BITS/8 payload bytes, mod 256. It occupies the frame LSB byte.
- busy: high in every state from WAIT through HOLD inclusive.
- Bus activity while driving: SDA edges during WAIT..END_L are ignored (the emulator owns the bus). A host pulse during HOLD is ignored and does not cause start_err.
- enable: deasserting mid-frame has no effect; the current frame completes.
- Saturation: a host low longer than the counter range saturates and is still accepted on release.

Test Plan:
- Defaults, sensor_data=32'h12345678, host low 1000 us then release → ack low 800 cycles, ack high 800 cycles, 40 bits. Decoded frame is 40'h1234567814 (checksum 0x14), frame_done pulses once, and busy drops 10000 cycles after END_L.
- Bit timing: check high widths for the first bit and the first one-bit → bit 0 (0) high 260 cycles, first 1 bit high 700 cycles, every low 500 cycles, first low starts exactly 300 cycles (+2 sync) after release.
- Host low 500 us → start_err single pulse, sda_oe stays 0, busy stays 0.
- CHKSUM_EN=0, DATA_BITS=16, data 16'hA5F0 → exactly 16 bits sent, pattern 1010010111110000, no checksum byte.
- RST_N asserted during bit 20 → sda_oe=0 in the same time step, busy=0. A next valid start then produces a full correct frame.
- Host low pulse issued during HOLD, and enable=0 at start → no response. With enable=1 after HOLD ends, a valid start is serviced normally.
